// File: rtl/ecc_decode_sched.sv
// Request/grant sequencer feeding one shared Hamming(15,11) decoder a chunk per cycle.
// Optional corrected-chunk counter is built only when ECC_ERRCNT_EN is defined.
module ecc_decode_sched #(
   parameter int NCHUNK = 24,
   parameter int K      = 11,
   parameter int P      = 4,
   parameter int CW     = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req,
   input  logic [NCHUNK*K-1:0]   data0,
   input  logic [NCHUNK*P-1:0]   helper0,
   input  logic [NCHUNK*K-1:0]   data1,
   input  logic [NCHUNK*P-1:0]   helper1,
   output logic [1:0]            gnt,
   output logic                  busy,
   output logic                  done,
   output logic [NCHUNK*K-1:0]   o_data,
   output logic [14:0]           dec_cw,
   input  logic [K-1:0]          dec_data,
   input  logic                  dec_err,
   output logic [CW-1:0]         err_cnt
);

   // IDLE: arbitrate | RUN: one chunk per cycle | DONE: one-cycle done, grant still held
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [NCHUNK*K-1:0]   r_data;
   logic [NCHUNK*P-1:0]   r_helper;
   logic [NCHUNK*K-1:0]   r_odata;
   logic [CW-1:0]         r_cnt;
   logic [1:0]            r_gnt;
   logic                  r_rr;
   logic                  w_pick;
   logic                  w_owner_req;
   logic                  w_abort;
   logic                  w_last;
   logic [K-1:0]          w_d;
   logic [P-1:0]          w_p;

   // r_rr remembers the last requester served; on contention the other one wins
   assign w_pick      = (req == 2'b11) ? ~r_rr : req[1];
   assign w_owner_req = r_gnt[1] ? req[1] : req[0];
   assign w_abort     = (r_state == S_RUN) && !w_owner_req;
   assign w_last      = (r_cnt == CW'(NCHUNK - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: if (|req) w_state_nxt = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (w_abort)     w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data   <= '0;
         r_helper <= '0;
         r_odata  <= '0;
         r_cnt    <= '0;
         r_gnt    <= '0;
         r_rr     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (|req) begin
               r_gnt    <= w_pick ? 2'b10 : 2'b01;
               r_rr     <= w_pick;
               r_data   <= w_pick ? data1 : data0;
               r_helper <= w_pick ? helper1 : helper0;
               r_cnt    <= '0;
            end
            S_RUN: begin
               if (w_abort) begin
                  r_gnt   <= '0;
                  r_odata <= '0;
                  r_cnt   <= '0;
               end else begin
                  for (int i = 0; i < NCHUNK; i++)
                     if (r_cnt == CW'(i)) r_odata[K*i +: K] <= dec_data;
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DONE: r_gnt <= '0;
            default: r_gnt <= '0;
         endcase
      end
   end

   // Current chunk out of the snapshot; codeword is interleaved at positions 1,2,4,8 for parity
   always_comb begin
      w_d = '0;
      w_p = '0;
      for (int i = 0; i < NCHUNK; i++)
         if (r_cnt == CW'(i)) begin
            w_d = r_data[K*i +: K];
            w_p = r_helper[P*i +: P];
         end
      dec_cw = '0;
      if (r_state == S_RUN)
         dec_cw = {w_d[10:4], w_p[3], w_d[3:1], w_p[2], w_d[0], w_p[1], w_p[0]};
   end

`ifdef ECC_ERRCNT_EN
   logic [CW-1:0] r_err_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         r_err_cnt <= '0;
      else if (r_state == S_IDLE && (|req))
         r_err_cnt <= '0;
      else if (r_state == S_RUN && !w_abort && dec_err && r_err_cnt != CW'(NCHUNK))
         r_err_cnt <= r_err_cnt + CW'(1);
   end

   assign err_cnt = r_err_cnt;
`else
   logic w_unused_dec_err;

   assign w_unused_dec_err = dec_err;
   assign err_cnt          = '0;
`endif

   assign gnt    = r_gnt;
   assign o_data = r_odata;

endmodule
